// File: rtl/arb_mux_n_pkg.sv
// Shared definitions for the arbitrated N-channel mux: mode encodings and the
// rotated-priority grant function used by the round-robin arbiter.
// Latency: n/a (definitions only). Backpressure: n/a.
package arb_mux_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  // Largest supported channel count and the index width that covers it.
  localparam int MAX_N    = 16;
  localparam int MAX_IDXW = 4;

  // One-hot grant for the first requester after ptr, searching ptr+1, ptr+2, ...
  // modulo n. The wrap uses n rather than a power of two, so non-power-of-two
  // channel counts never visit a nonexistent channel. ptr itself is searched last.
  function automatic logic [MAX_N-1:0] rr_grant(
    input logic [MAX_N-1:0]    req,
    input logic [MAX_IDXW-1:0] ptr,
    input int                  n
  );
    logic [MAX_N-1:0] g;
    logic             found;
    logic [31:0]      idx;
    g     = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_N; k++) begin
      if (k <= n) begin
        idx = (32'(ptr) + 32'(k)) % 32'(n);
        if (!found && req[idx[MAX_IDXW-1:0]]) begin
          g[idx[MAX_IDXW-1:0]] = 1'b1;
          found                = 1'b1;
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/arb_mux_n_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus its index, priority rotated past ptr.
// Latency: purely combinational, no state (the pointer lives in the parent).
// Backpressure: en = 0 forces an all-zero grant.
// Ports: req[N] requests, ptr last-granted index, en grant enable,
//        gnt[N] one-hot grant, gnt_idx index of the granted channel (0 if none).
module rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter  int N    = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  input  logic            en,
  output logic [N-1:0]    gnt,
  output logic [SELW-1:0] gnt_idx
);

  logic [MAX_N-1:0] req_ext;
  logic [MAX_N-1:0] gnt_ext;

  always_comb begin
    req_ext         = '0;
    req_ext[N-1:0]  = req;
    gnt_ext         = rr_grant(req_ext, MAX_IDXW'(ptr), N);
    gnt             = en ? gnt_ext[N-1:0] : '0;
    gnt_idx         = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) gnt_idx = SELW'(i);
    end
  end

endmodule

// File: rtl/arb_mux_n.sv
// N-channel arbitrated mux with a registered output beat, round-robin or fixed select.
// Latency: 1 cycle from input transfer to out_valid; 1 beat/cycle sustained.
// Backpressure: a held beat with out_ready low drops all in_ready; drain+load same cycle.
// Ports: clk/reset_n (sync, active-low); in_valid/in_ready/in_data per channel;
//        mode/sel choose RR or fixed channel; out_valid/out_ready/out_data/out_src.
module arb_mux_n
  import arb_mux_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  localparam int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_src
);

  localparam logic [SELW:0]   N_EXT    = (SELW+1)'(N);
  localparam logic [SELW-1:0] PTR_INIT = SELW'(N-1);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_src_q,   out_src_d;
  logic [SELW-1:0]  ptr_q,       ptr_d;

  logic             load_en;
  logic             arb_en;
  logic [N-1:0]     gnt_rr;
  logic [SELW-1:0]  gnt_rr_idx;
  logic [N-1:0]     gnt_fix;
  logic             sel_ok;
  logic [N-1:0]     grant;
  logic [SELW-1:0]  grant_idx;
  logic             xfer;
  logic [WIDTH-1:0] data_sel;

  // The register can take a new beat when empty or when the held one drains now;
  // this is the intended out_ready -> in_ready combinational path.
  assign load_en = !out_valid_q | out_ready;
  assign arb_en  = load_en & reset_n;

  rr_arbiter #(.N(N)) u_rr (
    .req     (in_valid),
    .ptr     (ptr_q),
    .en      (1'b1),
    .gnt     (gnt_rr),
    .gnt_idx (gnt_rr_idx)
  );

  always_comb begin
    // sel may exceed N-1 when N is not a power of two; such selects never grant.
    sel_ok  = ({1'b0, sel} < N_EXT);
    gnt_fix = '0;
    if (sel_ok && in_valid[sel]) gnt_fix[sel] = 1'b1;

    grant     = (mode == MODE_FIXED) ? gnt_fix : gnt_rr;
    grant_idx = (mode == MODE_FIXED) ? sel     : gnt_rr_idx;
    in_ready  = grant & {N{arb_en}};
    // Grants only ever go to valid channels, so any ready bit is a transfer.
    xfer      = |in_ready;

    data_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) data_sel = data_sel | in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = data_sel;
      out_src_d   = grant_idx;
      if (mode == MODE_RR) ptr_d = grant_idx;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      ptr_q       <= PTR_INIT;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule
